// File: rtl/mm_host_req_bridge_if.sv
// Host request/response and MM decoder strobe signals for mm_host_req_bridge.
// The slave modport is the bridge. The master modport is the host/decoder side.
interface mm_host_req_bridge_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 64
);
  logic              iREQ_V;
  logic              oREQ_RDY;
  logic              iREQ_WR;
  logic [ADDR_W-1:0] iREQ_ADDR;
  logic [DATA_W-1:0] iREQ_WDATA;
  logic              oRSP_V;
  logic              iRSP_RDY;
  logic [DATA_W-1:0] oRSP_DATA;
  logic              oRSP_ERR;
  logic              oMM_WR_EN;
  logic              oMM_RD_EN;
  logic [ADDR_W-1:0] oMM_ADDR;
  logic [DATA_W-1:0] oMM_WR_DATA;
  logic [DATA_W-1:0] iMM_RD_DATA;
  logic              iMM_RD_DATA_V;
  logic [15:0]       oTO_CNT;

  modport slave (
    input  iREQ_V, iREQ_WR, iREQ_ADDR, iREQ_WDATA, iRSP_RDY, iMM_RD_DATA, iMM_RD_DATA_V,
    output oREQ_RDY, oRSP_V, oRSP_DATA, oRSP_ERR, oMM_WR_EN, oMM_RD_EN, oMM_ADDR,
           oMM_WR_DATA, oTO_CNT
  );

  modport master (
    output iREQ_V, iREQ_WR, iREQ_ADDR, iREQ_WDATA, iRSP_RDY, iMM_RD_DATA, iMM_RD_DATA_V,
    input  oREQ_RDY, oRSP_V, oRSP_DATA, oRSP_ERR, oMM_WR_EN, oMM_RD_EN, oMM_ADDR,
           oMM_WR_DATA, oTO_CNT
  );
endinterface

// File: rtl/mm_host_req_bridge.sv
// Host valid/ready request bridge driving one-cycle MM decoder strobes.
// It handles posted writes and single outstanding reads with a timeout.
module mm_host_req_bridge #(
  parameter int                ADDR_W  = 14,
  parameter int                DATA_W  = 64,
  parameter int                TIMEOUT = 256,
  parameter logic [DATA_W-1:0] TO_DATA = 64'hDEAD_0000_0000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  mm_host_req_bridge_if.slave    bus
);
  localparam int                 TIMER_W   = $clog2(TIMEOUT) + 1;
  localparam logic [TIMER_W-1:0] TO_LAST   = TIMER_W'(TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] TIMER_MAX = '1;

  typedef enum logic [1:0] {IDLE, WAIT_RD, RSP} state_t;

  state_t              state_q, state_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic                rdy_q, rdy_d;
  logic                wr_en_q, wr_en_d;
  logic                rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                rsp_v_q, rsp_v_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                rsp_err_q, rsp_err_d;
  logic [15:0]         to_cnt_q, to_cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      rdy_q      <= 1'b0;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rsp_v_q    <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      to_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      rdy_q      <= rdy_d;
      wr_en_q    <= wr_en_d;
      rd_en_q    <= rd_en_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rsp_v_q    <= rsp_v_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      to_cnt_q   <= to_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    wr_en_d    = 1'b0;
    rd_en_d    = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rsp_v_d    = rsp_v_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    to_cnt_d   = to_cnt_q;

    case (state_q)
      IDLE: begin
        // The registered ready gates acceptance, so a request is never taken in the
        // first cycle after reset.
        if (bus.iREQ_V && rdy_q) begin
          addr_d = bus.iREQ_ADDR;
          if (bus.iREQ_WR) begin
            wr_en_d = 1'b1;
            wdata_d = bus.iREQ_WDATA;
          end else begin
            rd_en_d = 1'b1;
            timer_d = '0;
            state_d = WAIT_RD;
          end
        end
      end
      WAIT_RD: begin
        if (timer_q != TIMER_MAX) timer_d = timer_q + 1'b1;
        // Data arriving in the timeout cycle takes priority over the error.
        if (bus.iMM_RD_DATA_V) begin
          rsp_data_d = bus.iMM_RD_DATA;
          rsp_err_d  = 1'b0;
          rsp_v_d    = 1'b1;
          state_d    = RSP;
        end else if (timer_q == TO_LAST) begin
          rsp_data_d = TO_DATA | {{(DATA_W-ADDR_W){1'b0}}, addr_q};
          rsp_err_d  = 1'b1;
          rsp_v_d    = 1'b1;
          if (to_cnt_q != 16'hFFFF) to_cnt_d = to_cnt_q + 16'd1;
          state_d    = RSP;
        end
      end
      RSP: begin
        if (bus.iRSP_RDY) begin
          rsp_v_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    rdy_d = (state_d == IDLE);
  end

  assign bus.oREQ_RDY    = rdy_q;
  assign bus.oRSP_V      = rsp_v_q;
  assign bus.oRSP_DATA   = rsp_data_q;
  assign bus.oRSP_ERR    = rsp_err_q;
  assign bus.oMM_WR_EN   = wr_en_q;
  assign bus.oMM_RD_EN   = rd_en_q;
  assign bus.oMM_ADDR    = addr_q;
  assign bus.oMM_WR_DATA = wdata_q;
  assign bus.oTO_CNT     = to_cnt_q;
endmodule
